// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types and constants for the UART transmit frame sequencer.
// Line levels and state encodings are kept here so checkers can bind to them.
package uart_tx_ctrl_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Request/line bundle between a word source (master) and the frame sequencer (slave).
// Handshake: a word is taken in any IDLE cycle with Data_Valid=1 (par_load marks it);
// there is no backpressure other than busy, and requests seen while busy are dropped.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = uart_tx_ctrl_pkg::DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  par_bit;
  logic                  par_load;
  logic                  TX_OUT;
  logic                  busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, par_bit,
    input  par_load, TX_OUT, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, par_bit,
    output par_load, TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx_ctrl_tx_serializer.sv
// Data shift register and shift counter for one frame, LSB first.
// ser_data is the next bit to commit to the line; ser_done marks the last bit on the line.
module uart_tx_ctrl_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] p_data,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load) begin
      shift_d = p_data;
      cnt_d   = '0;
    end else if (shift_en) begin
      shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Each shift commits one bit to the output register, so after DATA_WIDTH
  // shifts the final data bit is the one currently on the line.
  assign ser_data = shift_q[0];
  assign ser_done = (cnt_q == CW'(DATA_WIDTH));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, data (LSB first), optional parity, stop bits,
// one bit per baud clock, with a registered serial output.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = uart_tx_ctrl_pkg::DATA_WIDTH,
  parameter int STOP_BITS  = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_tx_ctrl_if.slave        bus,
  output logic [2:0]           state_dbg
);

  import uart_tx_ctrl_pkg::*;

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_STOP   = STOP;

  logic [2:0] state_q, state_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       par_en_q, par_en_d;
  logic [1:0] stop_cnt_q, stop_cnt_d;
  logic       load, shift_en;
  logic       ser_data, ser_done;

  uart_tx_ctrl_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk      (CLK),
    .rst      (RST),
    .load     (load),
    .shift_en (shift_en),
    .p_data   (bus.P_DATA),
    .ser_data (ser_data),
    .ser_done (ser_done)
  );

  // tx_d is the level the line will carry in the state being entered,
  // which keeps TX_OUT a plain flop with no path from the inputs.
  always_comb begin
    state_d    = state_q;
    tx_d       = IDLE_BIT;
    par_en_d   = par_en_q;
    stop_cnt_d = stop_cnt_q;
    load       = 1'b0;
    shift_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.Data_Valid) begin
          state_d  = ST_START;
          tx_d     = START_BIT;
          load     = 1'b1;
          par_en_d = bus.PAR_EN;
        end
      end
      ST_START: begin
        state_d  = ST_DATA;
        tx_d     = ser_data;
        shift_en = 1'b1;
      end
      ST_DATA: begin
        if (!ser_done) begin
          tx_d     = ser_data;
          shift_en = 1'b1;
        end else if (par_en_q) begin
          state_d = ST_PARITY;
          tx_d    = bus.par_bit;
        end else begin
          state_d    = ST_STOP;
          tx_d       = STOP_BIT;
          stop_cnt_d = '0;
        end
      end
      ST_PARITY: begin
        state_d    = ST_STOP;
        tx_d       = STOP_BIT;
        stop_cnt_d = '0;
      end
      ST_STOP: begin
        if (stop_cnt_q == 2'(STOP_BITS - 1)) begin
          state_d = ST_IDLE;
          tx_d    = IDLE_BIT;
        end else begin
          stop_cnt_d = stop_cnt_q + 2'd1;
          tx_d       = STOP_BIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = IDLE_BIT;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      tx_q       <= IDLE_BIT;
      busy_q     <= 1'b0;
      par_en_q   <= 1'b0;
      stop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      par_en_q   <= par_en_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  assign bus.par_load = (state_q == ST_IDLE) && bus.Data_Valid;
  assign bus.TX_OUT   = tx_q;
  assign bus.busy     = busy_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: one instance with a single stop bit, one with two.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_uart_tx_ctrl;

  logic clk;
  logic rst;
  logic [2:0] state0, state1;
  int total;
  int bad;
  logic [0:0] exp_q[$];

  uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus0 ();
  uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus1 ();

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut0 (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus0),
    .state_dbg (state0)
  );

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) dut1 (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus1),
    .state_dbg (state1)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Bits are listed in line order, leftmost first.
  task automatic load_exp(input logic [15:0] bits, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(bits[n-1-i]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total += 4;
      if (bus0.TX_OUT !== 1'b1) begin bad++; $display("FAIL reset_tx0 c=%0d: got %b want 1", c, bus0.TX_OUT); end
      if (bus0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy0 c=%0d: got %b want 0", c, bus0.busy); end
      if (bus0.par_load !== 1'b0) begin bad++; $display("FAIL reset_pl0 c=%0d: got %b want 0", c, bus0.par_load); end
      if (state0 !== 3'd0) begin bad++; $display("FAIL reset_state0 c=%0d: got %0d want 0", c, state0); end
      total += 3;
      if (bus1.TX_OUT !== 1'b1) begin bad++; $display("FAIL reset_tx1 c=%0d: got %b want 1", c, bus1.TX_OUT); end
      if (bus1.busy !== 1'b0) begin bad++; $display("FAIL reset_busy1 c=%0d: got %b want 0", c, bus1.busy); end
      if (bus1.par_load !== 1'b0) begin bad++; $display("FAIL reset_pl1 c=%0d: got %b want 0", c, bus1.par_load); end
      next_cycle();
    end
  endtask

  task automatic test_parity_frame();
    logic [0:0] e;
    bus0.P_DATA = 8'hA5; bus0.PAR_EN = 1'b1; bus0.par_bit = 1'b0; bus0.Data_Valid = 1'b1;
    @(negedge clk);
    total++;
    if (bus0.par_load !== 1'b1) begin bad++; $display("FAIL par_accept_pl: got %b want 1", bus0.par_load); end
    next_cycle();
    bus0.Data_Valid = 1'b0; bus0.P_DATA = 8'h00; bus0.PAR_EN = 1'b0;
    load_exp(16'b0_10100101_0_1, 11);
    for (int c = 1; c <= 11; c++) begin
      e = exp_q.pop_front();
      @(negedge clk);
      total += 3;
      if (bus0.TX_OUT !== e) begin bad++; $display("FAIL par_line c=%0d: got %b want %b", c, bus0.TX_OUT, e); end
      if (bus0.busy !== 1'b1) begin bad++; $display("FAIL par_busy c=%0d: got %b want 1", c, bus0.busy); end
      if (bus0.par_load !== 1'b0) begin bad++; $display("FAIL par_pl c=%0d: got %b want 0", c, bus0.par_load); end
      next_cycle();
    end
    @(negedge clk);
    total += 2;
    if (bus0.busy !== 1'b0) begin bad++; $display("FAIL par_end_busy: got %b want 0", bus0.busy); end
    if (bus0.TX_OUT !== 1'b1) begin bad++; $display("FAIL par_end_tx: got %b want 1", bus0.TX_OUT); end
    next_cycle();
  endtask

  task automatic test_two_stop();
    logic [0:0] e;
    bus1.P_DATA = 8'h3C; bus1.PAR_EN = 1'b0; bus1.par_bit = 1'b1; bus1.Data_Valid = 1'b1;
    @(negedge clk);
    total++;
    if (bus1.par_load !== 1'b1) begin bad++; $display("FAIL stop2_pl: got %b want 1", bus1.par_load); end
    next_cycle();
    bus1.Data_Valid = 1'b0;
    load_exp(16'b0_00111100_11, 11);
    for (int c = 1; c <= 11; c++) begin
      e = exp_q.pop_front();
      @(negedge clk);
      total += 2;
      if (bus1.TX_OUT !== e) begin bad++; $display("FAIL stop2_line c=%0d: got %b want %b", c, bus1.TX_OUT, e); end
      if (bus1.busy !== 1'b1) begin bad++; $display("FAIL stop2_busy c=%0d: got %b want 1", c, bus1.busy); end
      next_cycle();
    end
    @(negedge clk);
    total += 2;
    if (bus1.busy !== 1'b0) begin bad++; $display("FAIL stop2_end_busy: got %b want 0", bus1.busy); end
    if (state1 !== 3'd0) begin bad++; $display("FAIL stop2_end_state: got %0d want 0", state1); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic exp_tx, exp_busy, exp_pl;
    bus0.PAR_EN = 1'b1; bus0.par_bit = 1'b1;
    for (int c = 0; c < 30; c++) begin
      bus0.Data_Valid = (c <= 12) || (c == 17);
      bus0.P_DATA = (c == 0) ? 8'h01 : 8'hFF;
      exp_tx = 1'b1;
      if (c == 1 || c == 13) exp_tx = 1'b0;
      if (c >= 3 && c <= 9) exp_tx = 1'b0;
      exp_busy = (c >= 1 && c <= 11) || (c >= 13 && c <= 23);
      exp_pl = (c == 0) || (c == 12);
      @(negedge clk);
      total += 3;
      if (bus0.TX_OUT !== exp_tx) begin bad++; $display("FAIL b2b_line c=%0d: got %b want %b", c, bus0.TX_OUT, exp_tx); end
      if (bus0.busy !== exp_busy) begin bad++; $display("FAIL b2b_busy c=%0d: got %b want %b", c, bus0.busy, exp_busy); end
      if (bus0.par_load !== exp_pl) begin bad++; $display("FAIL b2b_pl c=%0d: got %b want %b", c, bus0.par_load, exp_pl); end
      next_cycle();
    end
    bus0.Data_Valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [0:0] e;
    bus0.P_DATA = 8'h55; bus0.PAR_EN = 1'b0; bus0.par_bit = 1'b0; bus0.Data_Valid = 1'b1;
    next_cycle();
    bus0.Data_Valid = 1'b0;
    load_exp(16'b0_1010, 5);
    for (int c = 1; c <= 5; c++) begin
      e = exp_q.pop_front();
      if (c == 5) rst = 1'b1;
      @(negedge clk);
      total += 2;
      if (bus0.TX_OUT !== e) begin bad++; $display("FAIL mrst_line c=%0d: got %b want %b", c, bus0.TX_OUT, e); end
      if (bus0.busy !== 1'b1) begin bad++; $display("FAIL mrst_busy c=%0d: got %b want 1", c, bus0.busy); end
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    total += 3;
    if (bus0.TX_OUT !== 1'b1) begin bad++; $display("FAIL mrst_abort_tx: got %b want 1", bus0.TX_OUT); end
    if (bus0.busy !== 1'b0) begin bad++; $display("FAIL mrst_abort_busy: got %b want 0", bus0.busy); end
    if (state0 !== 3'd0) begin bad++; $display("FAIL mrst_abort_state: got %0d want 0", state0); end
    next_cycle();
    bus0.P_DATA = 8'h96; bus0.PAR_EN = 1'b1; bus0.par_bit = 1'b0; bus0.Data_Valid = 1'b1;
    @(negedge clk);
    total++;
    if (bus0.par_load !== 1'b1) begin bad++; $display("FAIL mrst_new_pl: got %b want 1", bus0.par_load); end
    next_cycle();
    bus0.Data_Valid = 1'b0;
    load_exp(16'b0_01101001_0_1, 11);
    for (int c = 1; c <= 11; c++) begin
      e = exp_q.pop_front();
      @(negedge clk);
      total += 2;
      if (bus0.TX_OUT !== e) begin bad++; $display("FAIL mrst_new_line c=%0d: got %b want %b", c, bus0.TX_OUT, e); end
      if (bus0.busy !== 1'b1) begin bad++; $display("FAIL mrst_new_busy c=%0d: got %b want 1", c, bus0.busy); end
      next_cycle();
    end
    @(negedge clk);
    total++;
    if (bus0.busy !== 1'b0) begin bad++; $display("FAIL mrst_new_end_busy: got %b want 0", bus0.busy); end
    next_cycle();
  endtask

  task automatic test_input_change();
    logic [0:0] e;
    bus0.P_DATA = 8'hF0; bus0.PAR_EN = 1'b0; bus0.par_bit = 1'b0; bus0.Data_Valid = 1'b1;
    next_cycle();
    bus0.Data_Valid = 1'b0; bus0.P_DATA = 8'h00; bus0.PAR_EN = 1'b1;
    load_exp(16'b0_00001111_1, 10);
    for (int c = 1; c <= 10; c++) begin
      e = exp_q.pop_front();
      @(negedge clk);
      total += 2;
      if (bus0.TX_OUT !== e) begin bad++; $display("FAIL chg_line c=%0d: got %b want %b", c, bus0.TX_OUT, e); end
      if (bus0.busy !== 1'b1) begin bad++; $display("FAIL chg_busy c=%0d: got %b want 1", c, bus0.busy); end
      next_cycle();
    end
    @(negedge clk);
    total += 2;
    if (bus0.busy !== 1'b0) begin bad++; $display("FAIL chg_end_busy: got %b want 0", bus0.busy); end
    if (bus0.TX_OUT !== 1'b1) begin bad++; $display("FAIL chg_end_tx: got %b want 1", bus0.TX_OUT); end
    next_cycle();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus0.P_DATA = 8'h00; bus0.Data_Valid = 1'b0; bus0.PAR_EN = 1'b0; bus0.par_bit = 1'b0;
    bus1.P_DATA = 8'h00; bus1.Data_Valid = 1'b0; bus1.PAR_EN = 1'b0; bus1.par_bit = 1'b0;
    next_cycle();
    test_reset();
    test_parity_frame();
    test_two_stop();
    test_back_to_back();
    test_mid_reset();
    test_input_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmitter. It accepts a parallel word on Data_Valid and latches it. It then drives the serial line through start, data, optional parity and stop phases, one bit per CLK cycle, because CLK is the TX baud clock. Parity is computed by the external parity block: this block issues the load strobe and consumes par_bit during the parity phase.

Parameters:
DATA_WIDTH, UART_PACKAGE::DATA_WIDTH (8), data bits per frame.
STOP_BITS, 1, number of stop-bit cycles (legal values 1 or 2).

Ports:
CLK  in  1  TX baud clock, all logic rising-edge.
RST  in  1  reset, synchronous, active-high.
P_DATA  in  DATA_WIDTH  word to send, sampled on acceptance.
Data_Valid  in  1  request to send P_DATA.
PAR_EN  in  1  parity phase enable, sampled on acceptance.
par_bit  in  1  parity bit from the parity block, stable from the cycle after par_load.
par_load  out  1  one-cycle strobe to the parity block (its Data_Valid) in the acceptance cycle.
TX_OUT  out  1  serial line, idle high.
busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - state <= IDLE, TX_OUT=1, busy=0, par_load=0.
  - The bit counter and data register are cleared.
  - This applies mid-frame too: the frame is aborted and the line reads 1 from the next cycle.
- Outputs are registered, including TX_OUT; there is no combinational path from inputs to TX_OUT.
- Acceptance: in IDLE with Data_Valid=1.
  - P_DATA goes to the shift register and PAR_EN to par_en_q; next state is START.
  - par_load is high in that same cycle. It is combinational from (state==IDLE && Data_Valid), so the parity block sees it alongside P_DATA.
- Data_Valid is ignored while busy=1. No queueing: a request during a frame is dropped.
- States and transitions:
  - IDLE: TX_OUT=1. Goes to START on acceptance.
  - START: TX_OUT=0, one cycle, then DATA.
  - DATA: TX_OUT=shift[0] (LSB first); shift right each cycle.
    - Counter counts 0..DATA_WIDTH-1.
    - At count DATA_WIDTH-1: next state is PARITY if par_en_q, else STOP.
  - PARITY: TX_OUT=par_bit, one cycle, then STOP.
  - STOP: TX_OUT=1 for STOP_BITS cycles, then IDLE.
- busy is high from the first START cycle through the last STOP cycle, and low in IDLE.
- Frame length is 1+DATA_WIDTH+par_en_q+STOP_BITS cycles.
- Back-to-back: with Data_Valid held high, the minimum period is frame length + 1 (one IDLE cycle between frames).
- Counter width is $clog2(DATA_WIDTH)+1 bits and is reset to 0 on each phase entry; there is no wrap inside a phase.
- An illegal or unreachable state encoding goes to IDLE with TX_OUT=1.
- P_DATA or PAR_EN changes after acceptance have no effect on the frame in flight.

Decomposition:
- UART_PACKAGE:
  - Add the typedef enum logic [2:0] tx_state_e {IDLE, START, DATA, PARITY, STOP}.
  - Add the constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_BIT=1'b1.
  - Reuse DATA_WIDTH.
- One sub-module is natural: tx_serializer (load, shift_en, P_DATA in; ser_data, ser_done out).
  - It holds the shift register and data-bit counter.
  - ser_done is high in the cycle the last data bit is on the line.
- The FSM, stop counter and output register stay in uart_tx_ctrl.

Test Plan:
- Reset, then idle 5 cycles -> TX_OUT=1, busy=0, par_load=0 every cycle.
- P_DATA=0xA5, PAR_EN=1, parity block even (par_bit=0) -> par_load pulses 1 cycle; TX_OUT = 0, 1,0,1,0,0,1,0,1, 0, 1; busy high for 11 cycles, then 0.
- P_DATA=0x3C, PAR_EN=0, STOP_BITS=2 -> TX_OUT = 0, 0,0,1,1,1,1,0,0, 1,1; 11 busy cycles; no parity cycle.
- Data_Valid held high with 0x01 then 0xFF, PAR_EN=1, par_bit=1 -> second start bit appears exactly 12 cycles after the first; requests pulsed during busy are dropped (only 2 frames on the line).
- RST asserted in the 4th DATA cycle of 0x55 -> TX_OUT=1 and busy=0 from the next cycle; a new request 2 cycles later produces a complete, correct frame.
- P_DATA changed to 0x00 one cycle after accepting 0xF0 -> the line still carries 0xF0 data bits 0,0,0,0,1,1,1,1.
